// File: rtl/regfile_mp.sv
// Multi-port integer register file: combinational reads with optional same-cycle
// write bypass, per-register busy scoreboard, and a post-reset init sweep.
module regfile_mp #(
  parameter int          XLEN     = 32,
  parameter int          NREG     = 32,
  parameter int          NRD      = 2,
  parameter int          NWR      = 2,
  parameter logic [31:0] INIT_VAL = 32'hDEADBEEF,
  parameter bit          BYPASS   = 1'b1,
  localparam int         AW       = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_addr,
  output logic                ready
);

  localparam logic [XLEN-1:0] INIT_X = XLEN'(INIT_VAL);
  localparam logic [AW-1:0]   LAST   = AW'(NREG - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [XLEN-1:0] mem [NREG];
  logic            running;

  assign running = (state_q == RUN);
  assign ready   = running;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= AW'(1);
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == INIT) begin
      ptr_d = ptr_q + AW'(1);
      if (ptr_q == LAST) state_d = RUN;
    end
  end

  // Clears are applied before the claim so a same-cycle claim leaves the register busy.
  always_comb begin
    busy_d = busy_q;
    if (running) begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w]) busy_d[wr_addr[w*AW +: AW]] = 1'b0;
      end
      if (claim_en) busy_d[claim_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Array has no reset; the sweep fills it. Later write ports override earlier ones.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[ptr_q] <= INIT_X;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] != '0))
          mem[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;

    assign ra = rd_addr[p*AW +: AW];

    always_comb begin
      rdat = mem[ra];
      if (BYPASS) begin
        for (int w = 0; w < NWR; w++) begin
          if (wr_en[w] && (wr_addr[w*AW +: AW] == ra))
            rdat = wr_data[w*XLEN +: XLEN];
        end
      end
      if (!running || (ra == '0)) rdat = '0;
    end

    assign rd_data[p*XLEN +: XLEN] = rdat;
    assign rd_busy[p]              = running & busy_q[ra];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: two instances (bypass on / off) share stimulus.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2*AW-1:0]   rd_addr;
  logic [2*XLEN-1:0] rd_data, rd_data_nb;
  logic [1:0]        rd_busy, rd_busy_nb;
  logic [1:0]        wr_en;
  logic [2*AW-1:0]   wr_addr;
  logic [2*XLEN-1:0] wr_data;
  logic              claim_en;
  logic [AW-1:0]     claim_addr;
  logic              ready, ready_nb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(2), .NWR(2),
               .INIT_VAL(32'hDEADBEEF), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .ready(ready));

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(2), .NWR(2),
               .INIT_VAL(32'hDEADBEEF), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .ready(ready_nb));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en    = 2'b00;
    wr_addr  = '0;
    wr_data  = '0;
    claim_en = 1'b0;
    claim_addr = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    rd_addr = {5'd0, 5'd5};
    step();
    #1;
    total++;
    if (ready !== 1'b0 || rd_busy !== 2'b00 || rd_data !== 64'h0) begin
      bad++;
      $display("FAIL reset_state ready=%b busy=%b data=%h expected 0/00/0", ready, rd_busy, rd_data);
    end
    rst_n = 1'b1;
    for (int i = 0; i < NREG - 1; i++) begin
      #1;
      total++;
      if (ready !== 1'b0 || ready_nb !== 1'b0 || rd_data[31:0] !== 32'h0) begin
        bad++;
        $display("FAIL init_ready cycle=%0d ready=%b data=%h expected ready=0 data=0", i, ready, rd_data[31:0]);
      end
      step();
    end
    #1;
    total++;
    if (ready !== 1'b1 || ready_nb !== 1'b1) begin
      bad++;
      $display("FAIL ready_rise got=%b/%b expected 1", ready, ready_nb);
    end
    total++;
    if (rd_data[31:0] !== 32'hDEADBEEF || rd_data[63:32] !== 32'h0) begin
      bad++;
      $display("FAIL init_value x5=%h x0=%h expected deadbeef/0", rd_data[31:0], rd_data[63:32]);
    end
    rd_addr = {5'd0, 5'd31};
    #1;
    total++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL init_last x31=%h expected deadbeef", rd_data[31:0]);
    end
  endtask

  task automatic test_x0();
    wr_en = 2'b01;
    wr_addr = {5'd0, 5'd0};
    wr_data = {32'h0, 32'h1234};
    rd_addr = {5'd0, 5'd0};
    #1;
    total++;
    if (rd_data[31:0] !== 32'h0) begin
      bad++;
      $display("FAIL x0_bypass got=%h expected 0", rd_data[31:0]);
    end
    step();
    idle_inputs();
    #1;
    total++;
    if (rd_data[31:0] !== 32'h0 || rd_data_nb[31:0] !== 32'h0) begin
      bad++;
      $display("FAIL x0_write got=%h/%h expected 0", rd_data[31:0], rd_data_nb[31:0]);
    end
    claim_en = 1'b1;
    claim_addr = 5'd0;
    step();
    claim_en = 1'b0;
    #1;
    total++;
    if (rd_busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL x0_busy got=%b expected 0", rd_busy[0]);
    end
  endtask

  task automatic test_bypass();
    wr_en = 2'b01;
    wr_addr = {5'd0, 5'd7};
    wr_data = {32'h0, 32'h11111111};
    step();
    wr_en = 2'b10;
    wr_addr = {5'd7, 5'd0};
    wr_data = {32'hA5A5A5A5, 32'h0};
    rd_addr = {5'd0, 5'd7};
    #1;
    total++;
    if (rd_data[31:0] !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL bypass_on got=%h expected a5a5a5a5", rd_data[31:0]);
    end
    total++;
    if (rd_data_nb[31:0] !== 32'h11111111) begin
      bad++;
      $display("FAIL bypass_off got=%h expected 11111111", rd_data_nb[31:0]);
    end
    step();
    idle_inputs();
    #1;
    total++;
    if (rd_data[31:0] !== 32'hA5A5A5A5 || rd_data_nb[31:0] !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL bypass_stored got=%h/%h expected a5a5a5a5", rd_data[31:0], rd_data_nb[31:0]);
    end
  endtask

  task automatic test_conflict();
    wr_en = 2'b11;
    wr_addr = {5'd3, 5'd3};
    wr_data = {32'd2, 32'd1};
    rd_addr = {5'd3, 5'd3};
    #1;
    total++;
    if (rd_data[31:0] !== 32'd2 || rd_data[63:32] !== 32'd2) begin
      bad++;
      $display("FAIL conflict_bypass got=%h/%h expected 2", rd_data[31:0], rd_data[63:32]);
    end
    step();
    idle_inputs();
    #1;
    total++;
    if (rd_data[31:0] !== 32'd2 || rd_data_nb[63:32] !== 32'd2) begin
      bad++;
      $display("FAIL conflict_stored got=%h/%h expected 2", rd_data[31:0], rd_data_nb[63:32]);
    end
  endtask

  task automatic test_busy();
    rd_addr = {5'd3, 5'd9};
    claim_en = 1'b1;
    claim_addr = 5'd9;
    #1;
    total++;
    if (rd_busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL busy_no_claim_bypass got=%b expected 0", rd_busy[0]);
    end
    step();
    claim_en = 1'b0;
    #1;
    total++;
    if (rd_busy !== 2'b01) begin
      bad++;
      $display("FAIL busy_claim got=%b expected 01", rd_busy);
    end
    wr_en = 2'b01;
    wr_addr = {5'd0, 5'd9};
    wr_data = {32'h0, 32'h99};
    #1;
    total++;
    if (rd_busy[0] !== 1'b1) begin
      bad++;
      $display("FAIL busy_no_clear_bypass got=%b expected 1", rd_busy[0]);
    end
    step();
    idle_inputs();
    #1;
    total++;
    if (rd_busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL busy_clear got=%b expected 0", rd_busy[0]);
    end
    wr_en = 2'b10;
    wr_addr = {5'd9, 5'd0};
    wr_data = {32'h77, 32'h0};
    claim_en = 1'b1;
    claim_addr = 5'd9;
    step();
    idle_inputs();
    #1;
    total++;
    if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h77) begin
      bad++;
      $display("FAIL busy_claim_and_write busy=%b data=%h expected 1/77", rd_busy[0], rd_data[31:0]);
    end
  endtask

  task automatic test_mid_reset();
    claim_en = 1'b1;
    claim_addr = 5'd4;
    step();
    idle_inputs();
    rd_addr = {5'd4, 5'd9};
    #1;
    total++;
    if (rd_busy !== 2'b11) begin
      bad++;
      $display("FAIL pre_reset_busy got=%b expected 11", rd_busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (ready !== 1'b0 || rd_busy !== 2'b00 || rd_data !== 64'h0) begin
      bad++;
      $display("FAIL async_reset ready=%b busy=%b data=%h expected 0/00/0", ready, rd_busy, rd_data);
    end
    step();
    rst_n = 1'b1;
    wr_en = 2'b01;
    wr_addr = {5'd0, 5'd5};
    wr_data = {32'h0, 32'h5555};
    claim_en = 1'b1;
    claim_addr = 5'd5;
    rd_addr = {5'd9, 5'd5};
    for (int i = 0; i < NREG - 1; i++) begin
      #1;
      total++;
      if (ready !== 1'b0 || rd_busy !== 2'b00) begin
        bad++;
        $display("FAIL resweep cycle=%0d ready=%b busy=%b expected 0/00", i, ready, rd_busy);
      end
      step();
    end
    idle_inputs();
    #1;
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL resweep_ready got=%b expected 1", ready);
    end
    total++;
    if (rd_data[31:0] !== 32'hDEADBEEF || rd_data[63:32] !== 32'hDEADBEEF || rd_busy !== 2'b00) begin
      bad++;
      $display("FAIL init_write_ignored x5=%h x9=%h busy=%b expected deadbeef/deadbeef/00",
               rd_data[31:0], rd_data[63:32], rd_busy);
    end
  endtask

  initial begin
    test_reset();
    test_x0();
    test_bypass();
    test_conflict();
    test_busy();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
